// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: state encoding,
// master indices and the default slave timeout.
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Grant state owned by a given master index
  function automatic logic [1:0] gnt_state(input logic idx);
    return (idx == M1) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall counter for the granted transfer; expired flags the last permitted
// silent cycle so the arbiter can turn it into a bus error.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone B3 classic arbiter with round-robin tie
// breaking, grant hold while cyc is high, and a silent-slave timeout.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  logic [1:0] state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       timed_out, timed_out_nxt;
  logic       req0, req1;
  logic       g0, g1;
  logic       state_chg;
  logic       ack_ok, err_ok;
  logic       tmo_en, tmo_expired, tmo_fire, tmo_clr;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign g0   = (state == ST_GNT0);
  assign g1   = (state == ST_GNT1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_gnt  <= M0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      timed_out <= timed_out_nxt;
    end
  end

  // Next state: round-robin from idle, hand over without a bubble on release
  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    timed_out_nxt = timed_out;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_nxt = (last_gnt == M0) ? gnt_state(M1) : gnt_state(M0);
        end else if (req0) begin
          state_nxt = gnt_state(M0);
        end else if (req1) begin
          state_nxt = gnt_state(M1);
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          last_gnt_nxt = M0;
          state_nxt    = req1 ? gnt_state(M1) : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          last_gnt_nxt = M1;
          state_nxt    = req0 ? gnt_state(M0) : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) begin
      timed_out_nxt = 1'b0;
    end else if (tmo_fire) begin
      timed_out_nxt = 1'b1;
    end
  end

  assign state_chg = (state_nxt != state);

  // Slave-side mux; a timed-out transfer keeps cyc but has its strobe withheld
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (g0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~timed_out;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (g1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~timed_out;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // Responses count only against a live strobe, so late acks are dropped
  assign ack_ok   = s_stb_o & s_ack_i & ~s_err_i;
  assign err_ok   = s_stb_o & s_err_i;
  assign tmo_en   = s_stb_o & ~s_ack_i & ~s_err_i;
  assign tmo_fire = tmo_en & tmo_expired;
  assign tmo_clr  = state_chg | s_ack_i | s_err_i | tmo_fire;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .en      (tmo_en),
    .clr     (tmo_clr),
    .expired (tmo_expired)
  );

  assign m0_dat_o = (state != ST_IDLE) ? s_dat_i : '0;
  assign m1_dat_o = (state != ST_IDLE) ? s_dat_i : '0;
  assign m0_ack_o = g0 & ack_ok;
  assign m1_ack_o = g1 & ack_ok;
  assign m0_err_o = g0 & (err_ok | tmo_fire);
  assign m1_err_o = g1 & (err_ok | tmo_fire);
  assign gnt_o    = {g1, g0};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: grant, round-robin, write path,
// timeout, simultaneous ack/err and mid-transfer reset.
module tb_wb_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic [3:0]    m0_sel_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [3:0]    m1_sel_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [3:0]    s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i;
  logic [1:0]    gnt_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m0_req(input logic on, input logic [31:0] adr);
    m0_cyc_i = on; m0_stb_i = on; m0_adr_i = adr;
  endtask

  task automatic m1_req(input logic on, input logic [31:0] adr);
    m1_cyc_i = on; m1_stb_i = on; m1_adr_i = adr;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF;
    s_dat_i = 32'h12345678; s_ack_i = 0; s_err_i = 0;
    tick(); tick(); #1;
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_stb", 64'(s_stb_o), 64'h0);
    chk("rst_m0_dat", 64'(m0_dat_o), 64'h0);
    chk("rst_m1_dat", 64'(m1_dat_o), 64'h0);

    // Single m0 read, slave acks on third grant cycle
    rst = 1'b0;
    m0_req(1, 32'h100); #1;
    chk("rd_pre_gnt", 64'(gnt_o), 64'h0);
    tick(); #1;
    chk("rd_gnt", 64'(gnt_o), 64'h1);
    chk("rd_adr", 64'(s_adr_o), 64'h100);
    chk("rd_stb", 64'(s_stb_o), 64'h1);
    chk("rd_no_ack", 64'(m0_ack_o), 64'h0);
    tick(); tick();
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF; #1;
    chk("rd_ack", 64'(m0_ack_o), 64'h1);
    chk("rd_dat", 64'(m0_dat_o), 64'hDEADBEEF);
    chk("rd_m1_ack", 64'(m1_ack_o), 64'h0);
    tick();
    s_ack_i = 0; m0_req(0, 32'h100); #1;
    chk("rd_rel_ack", 64'(m0_ack_o), 64'h0);
    tick(); #1;
    chk("rd_idle", 64'(gnt_o), 64'h0);

    // Tie after reset goes to m1; m1 performs a byte write
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req(1, 32'h100);
    m1_req(1, 32'h2000); m1_we_i = 1; m1_dat_i = 32'h000000AB; m1_sel_i = 4'h1;
    tick(); #1;
    chk("tie1_gnt", 64'(gnt_o), 64'h2);
    chk("wr_we", 64'(s_we_o), 64'h1);
    chk("wr_sel", 64'(s_sel_o), 64'h1);
    chk("wr_dat", 64'(s_dat_o), 64'hAB);
    chk("wr_adr", 64'(s_adr_o), 64'h2000);
    s_ack_i = 1; #1;
    chk("wr_ack", 64'(m1_ack_o), 64'h1);
    chk("wr_m0_ack", 64'(m0_ack_o), 64'h0);
    tick();
    s_ack_i = 0; m1_req(0, 32'h0); m1_we_i = 0; #1;
    chk("hand_hold", 64'(gnt_o), 64'h2);
    tick(); #1;
    chk("hand_m0", 64'(gnt_o), 64'h1);
    chk("hand_adr", 64'(s_adr_o), 64'h100);
    m0_req(0, 32'h0);
    tick(); #1;
    chk("hand_idle", 64'(gnt_o), 64'h0);

    // m0 served last -> next tie to m1
    m0_req(1, 32'h100); m1_req(1, 32'h2000);
    tick(); #1;
    chk("tie2_gnt", 64'(gnt_o), 64'h2);
    m1_req(0, 32'h0);
    tick(); #1;
    chk("tie2_hand", 64'(gnt_o), 64'h1);
    m0_req(0, 32'h0);
    tick();
    // m1 alone served last -> tie to m0
    m1_req(1, 32'h2000);
    tick(); #1;
    chk("solo_m1", 64'(gnt_o), 64'h2);
    m1_req(0, 32'h0);
    tick();
    m0_req(1, 32'h100); m1_req(1, 32'h2000);
    tick(); #1;
    chk("tie3_gnt", 64'(gnt_o), 64'h1);
    m0_req(0, 32'h0);
    tick(); #1;
    chk("tie3_hand", 64'(gnt_o), 64'h2);
    m1_req(0, 32'h0);
    tick(); #1;
    chk("tie3_idle", 64'(gnt_o), 64'h0);

    // Silent slave: error on 8th grant cycle, strobe withheld afterwards
    m0_req(1, 32'h300);
    tick(); #1;
    for (int i = 1; i <= 7; i++) begin
      chk("tmo_quiet", 64'(m0_err_o), 64'h0);
      chk("tmo_stb", 64'(s_stb_o), 64'h1);
      tick(); #1;
    end
    chk("tmo_err", 64'(m0_err_o), 64'h1);
    chk("tmo_m1_err", 64'(m1_err_o), 64'h0);
    tick(); #1;
    chk("tmo_pulse", 64'(m0_err_o), 64'h0);
    chk("tmo_stb_off", 64'(s_stb_o), 64'h0);
    chk("tmo_cyc", 64'(s_cyc_o), 64'h1);
    tick(); #1;
    chk("tmo_stb_off2", 64'(s_stb_o), 64'h0);
    m0_req(0, 32'h0);
    tick(); #1;
    chk("tmo_idle", 64'(gnt_o), 64'h0);

    // Simultaneous ack and err: err wins
    m0_req(1, 32'h400);
    tick(); #1;
    chk("ae_gnt", 64'(gnt_o), 64'h1);
    s_ack_i = 1; s_err_i = 1; #1;
    chk("ae_err", 64'(m0_err_o), 64'h1);
    chk("ae_ack", 64'(m0_ack_o), 64'h0);
    tick();
    s_ack_i = 0; s_err_i = 0; m0_req(0, 32'h0);
    tick();

    // Reset while m1 waits for its ack; late ack must be dropped
    m1_req(1, 32'h4000);
    tick(); #1;
    chk("rr_gnt", 64'(gnt_o), 64'h2);
    chk("rr_cyc", 64'(s_cyc_o), 64'h1);
    rst = 1'b1;
    tick(); #1;
    chk("rr_gnt_off", 64'(gnt_o), 64'h0);
    chk("rr_cyc_off", 64'(s_cyc_o), 64'h0);
    chk("rr_stb_off", 64'(s_stb_o), 64'h0);
    m1_req(0, 32'h0); rst = 1'b0; s_ack_i = 1; #1;
    chk("rr_late_m1", 64'(m1_ack_o), 64'h0);
    chk("rr_late_m0", 64'(m0_ack_o), 64'h0);
    tick(); #1;
    chk("rr_idle", 64'(gnt_o), 64'h0);
    s_ack_i = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
